// File: rtl/writeback_multi_if.sv
// ---------------------------------------------------------------------------
// writeback_multi_if
//   Bundles the two handshakes of the multi-lane writeback stage:
//     - memory-stage side: a valid/ready group transfer carrying LANES results
//     - register-file side: per-lane write strobes, addresses and data plus
//       the register file's ready for the head group
//
//   Signals
//     in_valid       memory stage presents a group
//     in_ready       writeback FIFO can accept a group
//     in_lane_valid  lane i carries a real instruction
//     in_wen         lane i requests a register write
//     in_wa          write address per lane, lane i at [i*AW +: AW]
//     in_wd          write data per lane, lane i at [i*XLEN +: XLEN]
//     rf_ready       register file accepts the head group this cycle
//     rf_wvalid      per-lane write enable towards the register file
//     rf_wa          per-lane write address
//     rf_wd          per-lane write data
//
//   Modports
//     slave   the writeback stage itself
//     master  the surrounding pipeline (memory stage and register file)
// ---------------------------------------------------------------------------
interface writeback_multi_if #(
  parameter int LANES = 2,
  parameter int XLEN  = 64,
  parameter int AW    = 5
);

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES-1:0]        in_lane_valid;
  logic [LANES-1:0]        in_wen;
  logic [LANES*AW-1:0]     in_wa;
  logic [LANES*XLEN-1:0]   in_wd;

  logic                    rf_ready;
  logic [LANES-1:0]        rf_wvalid;
  logic [LANES*AW-1:0]     rf_wa;
  logic [LANES*XLEN-1:0]   rf_wd;

  modport slave (
    input  in_valid,
    input  in_lane_valid,
    input  in_wen,
    input  in_wa,
    input  in_wd,
    input  rf_ready,
    output in_ready,
    output rf_wvalid,
    output rf_wa,
    output rf_wd
  );

  modport master (
    output in_valid,
    output in_lane_valid,
    output in_wen,
    output in_wa,
    output in_wd,
    output rf_ready,
    input  in_ready,
    input  rf_wvalid,
    input  rf_wa,
    input  rf_wd
  );

endinterface

// File: rtl/writeback_multi.sv
// ---------------------------------------------------------------------------
// writeback_multi
//   Multi-lane register-file writeback stage. Groups of LANES memory-stage
//   results are accepted through a valid/ready handshake and buffered in a
//   DEPTH-entry group FIFO. The head group drives LANES register-file write
//   ports; writes to x0 are suppressed and, when several lanes of one group
//   target the same register, only the youngest (highest) lane writes.
//   A 64-bit counter tracks retired lane-valid instructions.
//
//   Ports
//     clk      clock
//     resetn   synchronous active-low reset (pointers, count, retired)
//     bus      writeback_multi_if.slave: group input handshake and the
//              register-file write ports
//     flush    drop every buffered group; blocks push and pop this cycle
//     retired  count of retired lane-valid instructions, wraps mod 2^64
//     empty    FIFO holds no group
// ---------------------------------------------------------------------------
module writeback_multi #(
  parameter int LANES = 2,
  parameter int DEPTH = 2,
  parameter int XLEN  = 64,
  parameter int AW    = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  writeback_multi_if.slave     bus,
  input  logic                 flush,
  output logic [63:0]          retired,
  output logic                 empty
);

  localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]     ZERO_CNT = (PW+1)'(0);
  localparam logic [PW:0]     ONE_CNT  = (PW+1)'(1);
  localparam logic [PW-1:0]   ONE_PTR  = PW'(1);

  // Number of real instructions in a group; added to retired on each pop.
  function automatic logic [63:0] lane_popcount(input logic [LANES-1:0] v);
    logic [63:0] n;
    n = 64'd0;
    for (int k = 0; k < LANES; k++) begin
      n = n + {63'd0, v[k]};
    end
    return n;
  endfunction

  // Control state
  logic [PW-1:0]  rptr_q,    rptr_d;
  logic [PW-1:0]  wptr_q,    wptr_d;
  logic [PW:0]    count_q,   count_d;
  logic [63:0]    retired_q, retired_d;

  // Group storage; deliberately not reset, the pointers define validity
  logic [LANES-1:0]       lv_mem_q  [DEPTH];
  logic [LANES-1:0]       wen_mem_q [DEPTH];
  logic [LANES*AW-1:0]    wa_mem_q  [DEPTH];
  logic [LANES*XLEN-1:0]  wd_mem_q  [DEPTH];

  // Head group view and handshake qualifiers
  logic [LANES-1:0]       head_lv_s;
  logic [LANES-1:0]       head_wen_s;
  logic [LANES*AW-1:0]    head_wa_s;
  logic [LANES*XLEN-1:0]  head_wd_s;
  logic                   empty_s;
  logic                   in_ready_s;
  logic                   push_s;
  logic                   pop_s;
  logic [LANES-1:0]       lane_req_s;
  logic [LANES-1:0]       shadowed_s;
  logic [LANES-1:0]       rf_wvalid_s;

  assign head_lv_s  = lv_mem_q[rptr_q];
  assign head_wen_s = wen_mem_q[rptr_q];
  assign head_wa_s  = wa_mem_q[rptr_q];
  assign head_wd_s  = wd_mem_q[rptr_q];

  // Full is taken from registered count only: no pass-through when full.
  assign empty_s    = (count_q == ZERO_CNT);
  assign in_ready_s = (count_q != FULL_CNT);
  assign push_s     = bus.in_valid && in_ready_s && !flush;
  // resetn gates the pop so a reset cycle never issues register writes.
  assign pop_s      = !empty_s && bus.rf_ready && !flush && resetn;

  // Per-lane write request and same-address shadowing by younger lanes.
  always_comb begin
    lane_req_s = '0;
    shadowed_s = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_req_s[i] = head_lv_s[i] && head_wen_s[i];
    end
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if ((j > i) && lane_req_s[j] &&
            (head_wa_s[j*AW +: AW] == head_wa_s[i*AW +: AW])) begin
          shadowed_s[i] = 1'b1;
        end else begin
          shadowed_s[i] = shadowed_s[i];
        end
      end
    end
  end

  // Final write strobes: only on a pop, never to x0, never when shadowed.
  always_comb begin
    rf_wvalid_s = '0;
    for (int i = 0; i < LANES; i++) begin
      if (pop_s && lane_req_s[i] && !shadowed_s[i] &&
          (head_wa_s[i*AW +: AW] != {AW{1'b0}})) begin
        rf_wvalid_s[i] = 1'b1;
      end else begin
        rf_wvalid_s[i] = 1'b0;
      end
    end
  end

  // Next-state for pointers, occupancy and the retirement counter.
  always_comb begin
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    retired_d = retired_q;
    if (flush) begin
      // Discard everything buffered; retired is left untouched.
      rptr_d  = wptr_q;
      count_d = ZERO_CNT;
    end else begin
      if (push_s) begin
        wptr_d = wptr_q + ONE_PTR;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d    = rptr_q + ONE_PTR;
        retired_d = retired_q + lane_popcount(head_lv_s);
      end else begin
        rptr_d    = rptr_q;
        retired_d = retired_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rptr_q    <= {PW{1'b0}};
      wptr_q    <= {PW{1'b0}};
      count_q   <= ZERO_CNT;
      retired_q <= 64'd0;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      retired_q <= retired_d;
    end
  end

  // Group storage write on push; no reset so the array can map to RAM.
  always_ff @(posedge clk) begin
    if (push_s && resetn) begin
      lv_mem_q[wptr_q]  <= bus.in_lane_valid;
      wen_mem_q[wptr_q] <= bus.in_wen;
      wa_mem_q[wptr_q]  <= bus.in_wa;
      wd_mem_q[wptr_q]  <= bus.in_wd;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.rf_wvalid = rf_wvalid_s;
  assign bus.rf_wa     = head_wa_s;
  assign bus.rf_wd     = head_wd_s;
  assign retired       = retired_q;
  assign empty         = empty_s;

endmodule

// File: tb/tb_writeback_multi.sv
// ---------------------------------------------------------------------------
// tb_writeback_multi
//   Directed, table-driven bench for writeback_multi with LANES=2, DEPTH=2.
//   Each table row is one clock cycle: inputs are driven just after the
//   rising edge and outputs are compared at the falling edge. Mid-stream
//   reset and counter wrap are exercised by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_writeback_multi;

  localparam int LANES = 2;
  localparam int DEPTH = 2;
  localparam int XLEN  = 64;
  localparam int AW    = 5;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic [63:0] retired;
  logic        empty;

  int n_vec;
  int n_bad;

  writeback_multi_if #(.LANES(LANES), .XLEN(XLEN), .AW(AW)) bus ();

  writeback_multi #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .flush   (flush),
    .retired (retired),
    .empty   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [1:0]  lv;
    logic [1:0]  wen;
    logic [4:0]  wa0;
    logic [63:0] wd0;
    logic [4:0]  wa1;
    logic [63:0] wd1;
    logic        fl;
    logic        rr;
    logic        e_rdy;
    logic        e_empty;
    logic [1:0]  e_wv;
    logic [4:0]  e_wa0;
    logic [63:0] e_wd0;
    logic [4:0]  e_wa1;
    logic [63:0] e_wd1;
    logic [63:0] e_ret;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic iv, input logic [1:0] lv, input logic [1:0] wen,
    input logic [4:0] wa0, input logic [63:0] wd0,
    input logic [4:0] wa1, input logic [63:0] wd1,
    input logic fl, input logic rr,
    input logic e_rdy, input logic e_empty, input logic [1:0] e_wv,
    input logic [4:0] e_wa0, input logic [63:0] e_wd0,
    input logic [4:0] e_wa1, input logic [63:0] e_wd1,
    input logic [63:0] e_ret);
    vec_t v;
    v.iv = iv; v.lv = lv; v.wen = wen;
    v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.fl = fl; v.rr = rr;
    v.e_rdy = e_rdy; v.e_empty = e_empty; v.e_wv = e_wv;
    v.e_wa0 = e_wa0; v.e_wd0 = e_wd0; v.e_wa1 = e_wa1; v.e_wd1 = e_wd1;
    v.e_ret = e_ret;
    return v;
  endfunction

  // Idle cycle: no push, no flush, given rf_ready and expectations.
  function automatic vec_t idle(
    input logic rr, input logic e_rdy, input logic e_empty,
    input logic [1:0] e_wv, input logic [4:0] e_wa0, input logic [63:0] e_wd0,
    input logic [4:0] e_wa1, input logic [63:0] e_wd1, input logic [63:0] e_ret);
    return mk(1'b0, 2'b00, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, rr,
              e_rdy, e_empty, e_wv, e_wa0, e_wd0, e_wa1, e_wd1, e_ret);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [1:0] lv, input logic [1:0] wen,
                       input logic [4:0] wa0, input logic [63:0] wd0,
                       input logic [4:0] wa1, input logic [63:0] wd1,
                       input logic fl, input logic rr);
    bus.in_valid      = iv;
    bus.in_lane_valid = lv;
    bus.in_wen        = wen;
    bus.in_wa         = {wa1, wa0};
    bus.in_wd         = {wd1, wd0};
    flush             = fl;
    bus.rf_ready      = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input int k, input vec_t v);
    chk($sformatf("v%0d.in_ready", k), {63'd0, bus.in_ready}, {63'd0, v.e_rdy});
    chk($sformatf("v%0d.empty", k), {63'd0, empty}, {63'd0, v.e_empty});
    chk($sformatf("v%0d.wvalid", k), {62'd0, bus.rf_wvalid}, {62'd0, v.e_wv});
    chk($sformatf("v%0d.retired", k), retired, v.e_ret);
    if (v.e_wv[0]) begin
      chk($sformatf("v%0d.wa0", k), {59'd0, bus.rf_wa[4:0]}, {59'd0, v.e_wa0});
      chk($sformatf("v%0d.wd0", k), bus.rf_wd[63:0], v.e_wd0);
    end
    if (v.e_wv[1]) begin
      chk($sformatf("v%0d.wa1", k), {59'd0, bus.rf_wa[9:5]}, {59'd0, v.e_wa1});
      chk($sformatf("v%0d.wd1", k), bus.rf_wd[127:64], v.e_wd1);
    end
  endtask

  initial begin
    logic [63:0] all_ones;
    all_ones = 64'hFFFF_FFFF_FFFF_FFFF;
    n_vec = 0;
    n_bad = 0;

    // ---- table ---------------------------------------------------------
    // after reset
    vecs.push_back(idle(1'b1, 1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd0));
    // single push then write, retired +2
    vecs.push_back(mk(1'b1, 2'b11, 2'b11, 5'd3, 64'hAA, 5'd7, 64'hBB, 1'b0, 1'b1,
                      1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd0));
    vecs.push_back(idle(1'b1, 1'b1, 1'b0, 2'b11, 5'd3, 64'hAA, 5'd7, 64'hBB, 64'd0));
    vecs.push_back(idle(1'b1, 1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd2));
    // x0 on lane 0 suppressed
    vecs.push_back(mk(1'b1, 2'b11, 2'b11, 5'd0, 64'h11, 5'd9, 64'h22, 1'b0, 1'b1,
                      1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd2));
    vecs.push_back(idle(1'b1, 1'b1, 1'b0, 2'b10, 5'd0, 64'd0, 5'd9, 64'h22, 64'd2));
    // same-address collision, lane 1 wins
    vecs.push_back(mk(1'b1, 2'b11, 2'b11, 5'd5, 64'd1, 5'd5, 64'd2, 1'b0, 1'b1,
                      1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd4));
    vecs.push_back(idle(1'b1, 1'b1, 1'b0, 2'b10, 5'd0, 64'd0, 5'd5, 64'd2, 64'd4));
    // backpressure: fill, hold third, drain in order
    vecs.push_back(mk(1'b1, 2'b11, 2'b11, 5'd1, 64'h10, 5'd2, 64'h20, 1'b0, 1'b0,
                      1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd6));
    vecs.push_back(mk(1'b1, 2'b11, 2'b11, 5'd3, 64'h30, 5'd4, 64'h40, 1'b0, 1'b0,
                      1'b1, 1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd6));
    vecs.push_back(mk(1'b1, 2'b11, 2'b11, 5'd10, 64'hC0, 5'd11, 64'hC1, 1'b0, 1'b0,
                      1'b0, 1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd6));
    vecs.push_back(idle(1'b1, 1'b0, 1'b0, 2'b11, 5'd1, 64'h10, 5'd2, 64'h20, 64'd6));
    vecs.push_back(idle(1'b1, 1'b1, 1'b0, 2'b11, 5'd3, 64'h30, 5'd4, 64'h40, 64'd8));
    vecs.push_back(idle(1'b1, 1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd10));
    // simultaneous push/pop; invalid lane 1 does not shadow lane 0
    vecs.push_back(mk(1'b1, 2'b01, 2'b11, 5'd6, 64'hD0, 5'd6, 64'hD1, 1'b0, 1'b0,
                      1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd10));
    vecs.push_back(mk(1'b1, 2'b11, 2'b01, 5'd8, 64'hE0, 5'd8, 64'hE1, 1'b0, 1'b1,
                      1'b1, 1'b0, 2'b01, 5'd6, 64'hD0, 5'd0, 64'd0, 64'd10));
    vecs.push_back(idle(1'b1, 1'b1, 1'b0, 2'b01, 5'd8, 64'hE0, 5'd0, 64'd0, 64'd11));
    vecs.push_back(idle(1'b1, 1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd13));
    // group with no valid lanes pops and adds 0
    vecs.push_back(mk(1'b1, 2'b00, 2'b11, 5'd12, 64'hF0, 5'd13, 64'hF1, 1'b0, 1'b1,
                      1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd13));
    vecs.push_back(idle(1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd13));
    vecs.push_back(idle(1'b1, 1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd13));
    // flush with full FIFO
    vecs.push_back(mk(1'b1, 2'b11, 2'b11, 5'd14, 64'h14, 5'd15, 64'h15, 1'b0, 1'b0,
                      1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd13));
    vecs.push_back(mk(1'b1, 2'b11, 2'b11, 5'd16, 64'h16, 5'd17, 64'h17, 1'b0, 1'b0,
                      1'b1, 1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd13));
    vecs.push_back(mk(1'b1, 2'b11, 2'b11, 5'd20, 64'h20, 5'd21, 64'h21, 1'b1, 1'b1,
                      1'b0, 1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd13));
    vecs.push_back(idle(1'b1, 1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd13));
    // flush with room: incoming group dropped although in_ready=1
    vecs.push_back(mk(1'b1, 2'b11, 2'b11, 5'd22, 64'h22, 5'd23, 64'h23, 1'b0, 1'b0,
                      1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd13));
    vecs.push_back(mk(1'b1, 2'b11, 2'b11, 5'd24, 64'h24, 5'd25, 64'h25, 1'b1, 1'b1,
                      1'b1, 1'b0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd13));
    vecs.push_back(idle(1'b1, 1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd13));
    // normal operation resumes after flush
    vecs.push_back(mk(1'b1, 2'b11, 2'b11, 5'd18, 64'h1800, 5'd19, 64'h1900, 1'b0, 1'b0,
                      1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd13));
    vecs.push_back(idle(1'b1, 1'b1, 1'b0, 2'b11, 5'd18, 64'h1800, 5'd19, 64'h1900, 64'd13));
    vecs.push_back(idle(1'b1, 1'b1, 1'b1, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 64'd15));

    // ---- reset ---------------------------------------------------------
    resetn = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // ---- table loop ----------------------------------------------------
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].iv, vecs[k].lv, vecs[k].wen, vecs[k].wa0, vecs[k].wd0,
            vecs[k].wa1, vecs[k].wd1, vecs[k].fl, vecs[k].rr);
      @(negedge clk);
      check_vec(k, vecs[k]);
      tick();
    end

    // ---- mid-stream reset with a full FIFO -----------------------------
    drive(1'b1, 2'b11, 2'b11, 5'd26, 64'h26, 5'd27, 64'h27, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'b11, 2'b11, 5'd28, 64'h28, 5'd29, 64'h29, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b00, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst.full_before", {63'd0, bus.in_ready}, 64'd0);
    chk("rst.retired_before", retired, 64'd15);
    tick();
    resetn = 1'b1;
    bus.rf_ready = 1'b1;
    @(negedge clk);
    chk("rst.empty", {63'd0, empty}, 64'd1);
    chk("rst.retired", retired, 64'd0);
    chk("rst.wvalid", {62'd0, bus.rf_wvalid}, 64'd0);
    chk("rst.in_ready", {63'd0, bus.in_ready}, 64'd1);

    // ---- retired counter wrap ------------------------------------------
    force dut.retired_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retired_q;
    #1;
    chk("wrap.preload", retired, all_ones);
    tick();
    drive(1'b1, 2'b11, 2'b11, 5'd1, 64'h1, 5'd2, 64'h2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b00, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("wrap.wvalid", {62'd0, bus.rf_wvalid}, 64'd3);
    chk("wrap.retired_hold", retired, all_ones);
    tick();
    chk("wrap.retired", retired, 64'd1);
    chk("wrap.empty", {63'd0, empty}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_multi.md
Name: writeback_multi

Overview:
- Parametrised successor to the single-lane register-file writeback stage.
- Accepts groups of LANES memory-stage results through a valid/ready handshake and buffers them in a DEPTH-entry group FIFO.
- Drives LANES register-file write ports. Suppresses writes to x0 and resolves same-address write collisions within a group.
- Maintains a 64-bit retired-instruction counter. Sits between the memory stage and the register file.

Parameters:
- LANES, 2, number of parallel writeback lanes (1..4)
- DEPTH, 2, group FIFO entries (power of two, ≥2)
- XLEN, 64, data width of each write
- AW, 5, register address width

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- in_valid  in  1  memory stage presents a group
- in_ready  out  1  FIFO can accept a group
- in_lane_valid  in  LANES  lane i holds a real instruction
- in_wen  in  LANES  lane i requests a register write
- in_wa  in  LANES*AW  write address per lane (lane i at bits [i*AW +: AW])
- in_wd  in  LANES*XLEN  write data per lane
- flush  in  1  drop all buffered groups
- rf_ready  in  1  register file accepts the head group this cycle
- rf_wvalid  out  LANES  per-lane write enable to the register file
- rf_wa  out  LANES*AW  per-lane write address
- rf_wd  out  LANES*XLEN  per-lane write data
- retired  out  64  count of retired lane-valid instructions
- empty  out  1  FIFO holds no group

Behaviour:
- Clock and reset:
  - Single clock; reset is synchronous and active-low.
  - resetn=0 at a clock edge clears the read pointer, write pointer, count and retired.
  - It does not clear the FIFO data array.
  - After reset: in_ready=1, empty=1, rf_wvalid=0, retired=0.
  - Reset mid-stream discards all buffered groups with no writes issued.
- Push:
  - Occurs when in_valid && in_ready && !flush.
  - Stores lane_valid, wen, wa and wd for all lanes into entry wptr; wptr advances modulo DEPTH.
- FIFO status:
  - in_ready = (count != DEPTH).
  - Full is combinational from registered state. There is no same-cycle pass-through when full, even if a pop occurs that cycle.
- Latency:
  - A pushed group appears at the head the cycle after the push.
  - The head drives rf_wa and rf_wd combinationally from the FIFO entry.
  - rf_wa and rf_wd are don't-care when the corresponding rf_wvalid=0.
- Pop:
  - Occurs when !empty && rf_ready && !flush; rptr advances.
  - Push and pop in the same cycle leave count unchanged.
- rf_wvalid[i] = !empty && rf_ready && !flush && head.lane_valid[i] && head.wen[i] && head.wa[i] != 0 && no lane j>i in the head group with lane_valid[j] && wen[j] && wa[j] == wa[i].
  - In a collision the highest lane wins (program order: lane 0 oldest).
  - x0 writes are never issued.
- retired:
  - On each pop, retired += popcount(head.lane_valid).
  - Writes with wen=0 and writes to x0 still count.
  - The counter wraps modulo 2^64.
- flush:
  - Sets count=0 and rptr=wptr.
  - Blocks push and pop that cycle, forces rf_wvalid=0, and leaves retired unchanged.
  - in_ready may still be 1 during flush, but the group is dropped.
- Groups are all-or-nothing: a group pops only as a whole, never partially.
- Groups with lane_valid=0 in every lane may be pushed. They pop normally and add 0 to retired.

Test Plan:
1. Reset then single push:
   - Stimulus: LANES=2, lanes (wa=3, wd=0xAA) and (wa=7, wd=0xBB), both lane_valid and wen; rf_ready=1.
   - Response: next cycle rf_wvalid=2'b11 with those addresses and data; retired=2 the cycle after; empty=1.
2. x0 and collision:
   - Stimulus (a): lane0 wa=0. Response: rf_wvalid[0]=0.
   - Stimulus (b): lane0 wa=5 wd=1 and lane1 wa=5 wd=2. Response: only rf_wvalid[1]=1 with wd=2; retired still += 2.
3. Backpressure:
   - Stimulus: rf_ready=0, push DEPTH=2 groups.
   - Response: in_ready=0 after the second push; a third in_valid is held with no state change. Raising rf_ready drains both groups in order over 2 cycles, and in_ready returns to 1.
4. Simultaneous push/pop:
   - Stimulus: count=1, rf_ready=1, in_valid=1.
   - Response: count stays 1, the old group is written this cycle and the new group the next.
5. Flush:
   - Stimulus: 2 groups buffered, flush=1 with in_valid=1.
   - Response: empty=1 next cycle, rf_wvalid=0 during the flush cycle, retired unchanged, incoming group dropped.
6. Mid-stream reset and wrap:
   - Stimulus (a): resetn=0 with a full FIFO. Response: next cycle empty=1, retired=0, rf_wvalid=0.
   - Stimulus (b): preload retired near 2^64-1 via repeated pops (or force), then pop. Response: retired wraps to the low bits of the sum.
